ovl_incr_stim_ctrl: RTL and testbench

Sequencer that drives the `test_expr` input of an `ovl_increment` checker in the OVL regression benches. Each run is started by one command and steps a counter by a fixed increment, holding each value for a programmable number of cycles. The block can corrupt the last step on request to exercise the checker's fire path. For every step it reports whether the checker is expected to fire, so a bench can compare that against the checker's actual fire output.

---
 rtl/ovl_incr_stim_ctrl.sv | 98 +++++++++
 tb/tb_ovl_incr_stim_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ovl_incr_stim_ctrl.sv
// ovl_incr_stim_ctrl: steps test_expr by INCR per held step, optionally corrupting the last step, and predicts ovl_increment fires
module ovl_incr_stim_ctrl #(
  parameter int WIDTH = 4,
  parameter int INCR  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [7:0]       num_steps,
  input  logic [3:0]       hold_cycles,
  input  logic             inject_err,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] test_expr,
  output logic [7:0]       step_cnt,
  output logic             fire_expected
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [3:0]       hold_q, hold_d, h_q, h_d;
  logic [7:0]       n_q, n_d, step_q, step_d;
  logic             inj_q, inj_d, done_q, done_d, fire_q, fire_d;
  logic [WIDTH-1:0] test_q, test_d;
  logic             last;
  logic [WIDTH:0]   delta, sum;
  assign last  = step_q + 8'd1 == n_q;
  assign delta = (last && inj_q) ? (WIDTH+1)'(INCR + 1) : (WIDTH+1)'(INCR);
  // one extra bit catches the wrap the checker will flag
  assign sum   = {1'b0, test_q} + delta;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    h_d     = h_q;
    n_d     = n_q;
    inj_d   = inj_q;
    step_d  = step_q;
    test_d  = test_q;
    done_d  = done_q;
    fire_d  = fire_q;
    if (enable) begin
      done_d = 1'b0;
      fire_d = 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          n_d   = num_steps;
          h_d   = hold_cycles;
          inj_d = inject_err;
          if (num_steps == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            step_d  = 8'd0;
            hold_d  = 4'd0;
          end
        end
      end else if (hold_q == h_q) begin
        hold_d  = 4'd0;
        test_d  = sum[WIDTH-1:0];
        step_d  = step_q + 8'd1;
        fire_d  = (last && inj_q) || sum[WIDTH];
        state_d = last ? IDLE : RUN;
        done_d  = last;
      end else begin
        hold_d = hold_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      h_q     <= '0;
      n_q     <= '0;
      inj_q   <= 1'b0;
      step_q  <= '0;
      test_q  <= '0;
      done_q  <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      h_q     <= h_d;
      n_q     <= n_d;
      inj_q   <= inj_d;
      step_q  <= step_d;
      test_q  <= test_d;
      done_q  <= done_d;
      fire_q  <= fire_d;
    end
  end
  assign busy          = state_q == RUN;
  assign done          = done_q;
  assign test_expr     = test_q;
  assign step_cnt      = step_q;
  assign fire_expected = fire_q;
endmodule

// File: tb/tb_ovl_incr_stim_ctrl.sv
// tb_ovl_incr_stim_ctrl: directed scenarios for ovl_incr_stim_ctrl with WIDTH=4, INCR=2
module tb_ovl_incr_stim_ctrl;
  logic       clock = 1'b0;
  logic       reset, enable, start, inject_err;
  logic [7:0] num_steps;
  logic [3:0] hold_cycles;
  logic       busy, done, fire_expected;
  logic [3:0] test_expr;
  logic [7:0] step_cnt;
  int checks = 0;
  int errors = 0;
  ovl_incr_stim_ctrl #(.WIDTH(4), .INCR(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .num_steps(num_steps), .hold_cycles(hold_cycles), .inject_err(inject_err),
    .busy(busy), .done(done), .test_expr(test_expr), .step_cnt(step_cnt),
    .fire_expected(fire_expected)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic expect_out(input string tag, input int te, input int b, input int d, input int f, input int s);
    check({tag, ".te"}, 32'(test_expr), te);
    check({tag, ".busy"}, 32'(busy), b);
    check({tag, ".done"}, 32'(done), d);
    check({tag, ".fire"}, 32'(fire_expected), f);
    check({tag, ".step"}, 32'(step_cnt), s);
  endtask
  task automatic go(input int n, input int h, input logic inj);
    start = 1'b1;
    num_steps = 8'(n);
    hold_cycles = 4'(h);
    inject_err = inj;
    tick();
    start = 1'b0;
    num_steps = 8'($urandom);
    hold_cycles = 4'($urandom);
    inject_err = 1'($urandom);
  endtask
  initial begin
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      num_steps = 8'($urandom_range(1, 255));
      hold_cycles = 4'($urandom);
      inject_err = 1'($urandom);
      tick();
      expect_out($sformatf("rst%0d", i), 0, 0, 0, 0, 0);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    expect_out("rel", 0, 0, 0, 0, 0);
    // basic run
    go(3, 0, 1'b0);
    expect_out("b.k", 0, 1, 0, 0, 0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      expect_out($sformatf("b.s%0d", j), 2 * j, j < 3, j == 3, 0, j);
    end
    tick();
    expect_out("b.end", 6, 0, 0, 0, 3);
    // hold
    go(2, 2, 1'b0);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) tick();
      expect_out($sformatf("h.c%0d", c), c < 3 ? 6 : (c < 6 ? 8 : 10), c < 6, c == 6, 0, c / 3);
    end
    tick();
    expect_out("h.end", 10, 0, 0, 0, 2);
    // error injection: 14+3 corrupts and wraps to 1
    go(3, 0, 1'b1);
    tick(); expect_out("e.s1", 12, 1, 0, 0, 1);
    tick(); expect_out("e.s2", 14, 1, 0, 0, 2);
    tick(); expect_out("e.s3", 1, 0, 1, 1, 3);
    tick(); expect_out("e.end", 1, 0, 0, 0, 3);
    // wrap from 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("w.rst", 0, 0, 0, 0, 0);
    go(8, 0, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      expect_out($sformatf("w.s%0d", j), (2 * j) % 16, j < 8, j == 8, j == 8, j);
    end
    // N=0 twice back to back: second accept happens while done=1
    start = 1'b1;
    num_steps = 8'd0;
    tick(); expect_out("z.a", 0, 0, 1, 0, 8);
    tick(); expect_out("z.b", 0, 0, 1, 0, 8);
    start = 1'b0;
    tick(); expect_out("z.end", 0, 0, 0, 0, 8);
    // start while disabled is ignored
    enable = 1'b0;
    start = 1'b1;
    num_steps = 8'd5;
    tick(); tick();
    expect_out("dis", 0, 0, 0, 0, 8);
    enable = 1'b1;
    start = 1'b0;
    tick();
    // enable drop mid-hold, start while busy, reset mid-run
    go(4, 1, 1'b0);
    expect_out("c.k", 0, 1, 0, 0, 0);
    tick(); expect_out("c.k1", 0, 1, 0, 0, 0);
    tick(); expect_out("c.k2", 2, 1, 0, 0, 1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("c.frz%0d", i), 2, 1, 0, 0, 1);
    end
    enable = 1'b1;
    start = 1'b1;
    num_steps = 8'd1;
    tick(); expect_out("c.k6", 2, 1, 0, 0, 1);
    start = 1'b0;
    tick(); expect_out("c.k7", 4, 1, 0, 0, 2);
    reset = 1'b1;
    tick(); expect_out("c.rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick(); expect_out("c.idle", 0, 0, 0, 0, 0);
    go(3, 0, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      tick();
      expect_out($sformatf("f.s%0d", j), 2 * j, j < 3, j == 3, 0, j);
    end
    // done pulse stretches while disabled
    enable = 1'b0;
    tick(); expect_out("f.hold", 6, 0, 1, 0, 3);
    enable = 1'b1;
    tick(); expect_out("f.end", 6, 0, 0, 0, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
